// File: rtl/palette_ram.sv
// palette_ram - multi-bank colour lookup table with vsync-aligned bank swap and fade engine.
// Two-stage pixel pipeline: palette read, then saturating attenuation and blanking.
module palette_ram #(
  parameter int IDX_W           = 4,
  parameter int CH_W            = 4,
  parameter int NUM_BANKS       = 2,
  parameter int FRAMES_PER_STEP = 2,
  localparam int BW             = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [IDX_W-1:0]  pix_index,
  input  logic              pix_blank,
  input  logic              vsync_pulse,
  input  logic              wr_en,
  input  logic [BW-1:0]     wr_bank,
  input  logic [IDX_W-1:0]  wr_addr,
  input  logic [3*CH_W-1:0] wr_data,
  input  logic              swap_req,
  input  logic [BW-1:0]     swap_bank,
  input  logic              fade_go,
  input  logic              fade_dir,
  output logic [CH_W-1:0]   red,
  output logic [CH_W-1:0]   green,
  output logic [CH_W-1:0]   blue,
  output logic [BW-1:0]     active_bank,
  output logic              swap_pending,
  output logic              fade_busy,
  output logic [CH_W-1:0]   fade_level
);

  localparam int ENTRIES = 2 ** IDX_W;
  localparam int CNT_W   = $clog2(FRAMES_PER_STEP + 1);
  localparam logic [CH_W-1:0] LVL_MAX = '1;

  typedef enum logic {IDLE, FADING} state_t;

  // Built-in palette; each 4-bit nibble is scaled up to the channel width.
  function automatic logic [3*CH_W-1:0] init_entry(input int e);
    logic [11:0]     v;
    logic [CH_W-1:0] r, g, b;
    case (e)
      0:       v = 12'h000;
      2:       v = 12'hE81;
      3:       v = 12'hFFF;
      4:       v = 12'h4E2;
      default: v = 12'h3CD;
    endcase
    r = CH_W'(v[11:8]) << (CH_W - 4);
    g = CH_W'(v[7:4])  << (CH_W - 4);
    b = CH_W'(v[3:0])  << (CH_W - 4);
    return {r, g, b};
  endfunction

  function automatic logic [CH_W-1:0] sat_sub(input logic [CH_W-1:0] a, input logic [CH_W-1:0] b);
    return (a > b) ? (a - b) : '0;
  endfunction

  logic [3*CH_W-1:0] mem_q [NUM_BANKS][ENTRIES];
  logic [3*CH_W-1:0] mem_d [NUM_BANKS][ENTRIES];
  logic [3*CH_W-1:0] s1_q, s1_d;
  logic              blank1_q, blank1_d;
  logic [CH_W-1:0]   red_q, red_d, green_q, green_d, blue_q, blue_d;
  logic [BW-1:0]     active_q, active_d, pend_q, pend_d;
  logic              spend_q, spend_d;
  state_t            state_q, state_d;
  logic [CH_W-1:0]   level_q, level_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              dir_q, dir_d;
  logic [CH_W-1:0]   tgt_go, tgt_cur;

  always_comb begin
    mem_d = mem_q;
    if (wr_en && (32'(wr_bank) < NUM_BANKS)) mem_d[wr_bank][wr_addr] = wr_data;
  end

  always_comb begin
    s1_d     = mem_q[active_q][pix_index];
    blank1_d = pix_blank;
    red_d    = blank1_q ? '0 : sat_sub(s1_q[3*CH_W-1:2*CH_W], level_q);
    green_d  = blank1_q ? '0 : sat_sub(s1_q[2*CH_W-1:CH_W], level_q);
    blue_d   = blank1_q ? '0 : sat_sub(s1_q[CH_W-1:0], level_q);
  end

  // A request arriving with vsync is folded in before the swap is applied.
  always_comb begin
    pend_d   = pend_q;
    spend_d  = spend_q;
    active_d = active_q;
    if (swap_req && (32'(swap_bank) < NUM_BANKS)) begin
      pend_d  = swap_bank;
      spend_d = 1'b1;
    end
    if (vsync_pulse && spend_d) begin
      active_d = pend_d;
      spend_d  = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    level_d = level_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    tgt_go  = fade_dir ? LVL_MAX : '0;
    tgt_cur = dir_q ? LVL_MAX : '0;
    if (fade_go) begin
      cnt_d = '0;
      if (level_q == tgt_go) begin
        state_d = IDLE;
      end else begin
        state_d = FADING;
        dir_d   = fade_dir;
      end
    end else if (state_q == FADING && vsync_pulse) begin
      if (cnt_q == CNT_W'(FRAMES_PER_STEP - 1)) begin
        cnt_d   = '0;
        level_d = dir_q ? (level_q + CH_W'(1)) : (level_q - CH_W'(1));
        if (level_d == tgt_cur) state_d = IDLE;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int b = 0; b < NUM_BANKS; b++)
        for (int e = 0; e < ENTRIES; e++)
          mem_q[b][e] <= init_entry(e);
      s1_q     <= '0;
      blank1_q <= 1'b0;
      red_q    <= '0;
      green_q  <= '0;
      blue_q   <= '0;
      active_q <= '0;
      pend_q   <= '0;
      spend_q  <= 1'b0;
      state_q  <= IDLE;
      level_q  <= '0;
      cnt_q    <= '0;
      dir_q    <= 1'b0;
    end else begin
      mem_q    <= mem_d;
      s1_q     <= s1_d;
      blank1_q <= blank1_d;
      red_q    <= red_d;
      green_q  <= green_d;
      blue_q   <= blue_d;
      active_q <= active_d;
      pend_q   <= pend_d;
      spend_q  <= spend_d;
      state_q  <= state_d;
      level_q  <= level_d;
      cnt_q    <= cnt_d;
      dir_q    <= dir_d;
    end
  end

  assign red          = red_q;
  assign green        = green_q;
  assign blue         = blue_q;
  assign active_bank  = active_q;
  assign swap_pending = spend_q;
  assign fade_busy    = (state_q == FADING);
  assign fade_level   = level_q;

endmodule

// File: tb/tb_palette_ram.sv
// tb_palette_ram - directed self-checking bench for palette_ram.
module tb_palette_ram;

  localparam int IDX_W = 4;
  localparam int CH_W  = 4;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [IDX_W-1:0]  pix_index = '0;
  logic              pix_blank = 1'b0;
  logic              vsync_pulse = 1'b0;
  logic              wr_en = 1'b0;
  logic [0:0]        wr_bank = '0;
  logic [IDX_W-1:0]  wr_addr = '0;
  logic [3*CH_W-1:0] wr_data = '0;
  logic              swap_req = 1'b0;
  logic [0:0]        swap_bank = '0;
  logic              fade_go = 1'b0;
  logic              fade_dir = 1'b0;
  logic [CH_W-1:0]   red, green, blue, fade_level;
  logic [0:0]        active_bank;
  logic              swap_pending, fade_busy;

  int n_checks = 0;
  int n_fail   = 0;

  palette_ram #(.IDX_W(IDX_W), .CH_W(CH_W), .NUM_BANKS(2), .FRAMES_PER_STEP(2)) dut (
    .clk(clk), .reset_n(reset_n), .pix_index(pix_index), .pix_blank(pix_blank),
    .vsync_pulse(vsync_pulse), .wr_en(wr_en), .wr_bank(wr_bank), .wr_addr(wr_addr),
    .wr_data(wr_data), .swap_req(swap_req), .swap_bank(swap_bank), .fade_go(fade_go),
    .fade_dir(fade_dir), .red(red), .green(green), .blue(blue), .active_bank(active_bank),
    .swap_pending(swap_pending), .fade_busy(fade_busy), .fade_level(fade_level)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic show(input string tag, input logic [IDX_W-1:0] idx, input logic blk,
                      input logic [11:0] exp);
    pix_index = idx;
    pix_blank = blk;
    tick();
    tick();
    check(tag, {20'h0, red, green, blue}, {20'h0, exp});
  endtask

  task automatic vsync(input int n);
    for (int i = 0; i < n; i++) begin
      vsync_pulse = 1'b1;
      tick();
      vsync_pulse = 1'b0;
      tick();
    end
  endtask

  task automatic write(input logic b, input logic [IDX_W-1:0] a, input logic [11:0] d);
    wr_en = 1'b1; wr_bank = b; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic go(input logic dir);
    fade_go = 1'b1; fade_dir = dir;
    tick();
    fade_go = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    check("rst_rgb", {red, green, blue}, 12'h000);
    check("rst_bank", active_bank, 0);
    check("rst_pend", swap_pending, 0);
    check("rst_busy", fade_busy, 0);
    check("rst_level", fade_level, 0);
    @(negedge clk);
    reset_n = 1'b1;
    tick();

    show("idx2", 2, 0, 12'hE81);
    show("idx7", 7, 0, 12'h3CD);

    // Staged write then mid-frame swap request
    write(1, 3, 12'h123);
    swap_req = 1'b1; swap_bank = 1;
    tick();
    swap_req = 1'b0;
    check("pend_set", swap_pending, 1);
    show("idx3_old", 3, 0, 12'hFFF);
    check("bank_hold", active_bank, 0);
    vsync(1);
    check("bank_swapped", active_bank, 1);
    check("pend_clr", swap_pending, 0);
    show("idx3_new", 3, 0, 12'h123);

    // Write the displayed entry in the same cycle it is read
    pix_index = 5;
    wr_en = 1'b1; wr_bank = 1; wr_addr = 5; wr_data = 12'hABC;
    tick();
    wr_en = 1'b0;
    tick();
    check("rw_old", {red, green, blue}, 12'h3CD);
    tick();
    check("rw_new", {red, green, blue}, 12'hABC);

    // Request arriving together with vsync applies immediately
    swap_req = 1'b1; swap_bank = 0; vsync_pulse = 1'b1;
    tick();
    swap_req = 1'b0; vsync_pulse = 1'b0;
    check("same_cyc_bank", active_bank, 0);
    check("same_cyc_pend", swap_pending, 0);

    // Fade out
    go(1);
    check("fo_busy", fade_busy, 1);
    vsync(1);
    check("fo_lvl_v1", fade_level, 0);
    vsync(1);
    check("fo_lvl_v2", fade_level, 1);
    show("fo_idx2_l1", 2, 0, 12'hD70);
    vsync(26);
    check("fo_lvl14", fade_level, 14);
    check("fo_busy14", fade_busy, 1);
    vsync(2);
    check("fo_lvl15", fade_level, 15);
    check("fo_done", fade_busy, 0);
    show("fo_idx2_blk", 2, 0, 12'h000);
    show("fo_idx3_blk", 3, 0, 12'h000);
    go(1);
    check("fo_at_tgt", fade_busy, 0);

    // Fade in, then reverse mid-fade with a coincident vsync
    go(0);
    check("fi_busy", fade_busy, 1);
    vsync(2);
    check("fi_lvl14", fade_level, 14);
    fade_go = 1'b1; fade_dir = 1'b1; vsync_pulse = 1'b1;
    tick();
    fade_go = 1'b0; vsync_pulse = 1'b0;
    check("rev_nostep", fade_level, 14);
    check("rev_busy", fade_busy, 1);
    vsync(1);
    check("rev_cnt", fade_level, 14);
    vsync(1);
    check("rev_lvl15", fade_level, 15);
    check("rev_done", fade_busy, 0);
    go(0);
    vsync(30);
    check("fi_lvl0", fade_level, 0);
    check("fi_done", fade_busy, 0);
    show("fi_idx2", 2, 0, 12'hE81);

    show("blank2", 2, 1, 12'h000);
    show("blank4", 4, 1, 12'h000);
    show("idx4", 4, 0, 12'h4E2);

    // Reset in the middle of a fade with a swap pending
    write(0, 1, 12'h777);
    show("wr_b0e1", 1, 0, 12'h777);
    go(1);
    vsync(2);
    check("mid_lvl1", fade_level, 1);
    swap_req = 1'b1; swap_bank = 1;
    tick();
    swap_req = 1'b0;
    pix_index = 2;
    tick();
    tick();
    check("pre_rst_pend", swap_pending, 1);
    check("pre_rst_rgb", {red, green, blue}, 12'hD70);
    reset_n = 1'b0;
    #1;
    check("mr_rgb", {red, green, blue}, 12'h000);
    check("mr_bank", active_bank, 0);
    check("mr_pend", swap_pending, 0);
    check("mr_busy", fade_busy, 0);
    check("mr_level", fade_level, 0);
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    show("mr_idx1", 1, 0, 12'h3CD);
    show("mr_idx2", 2, 0, 12'hE81);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/palette_ram.md
Name: palette_ram

Overview:
- Writable, multi-bank colour lookup table that maps a per-pixel palette index to RGB for the VGA output path.
- The drawing logic writes entries at runtime.
- The active bank swaps only on a frame boundary, which allows tear-free palette changes.
- A frame-synchronous fade engine dims output toward black, or restores it, for screen transitions.
- Sits between the sprite/background compositor and the VGA DAC pins.

Parameters:
IDX_W, 4, palette index width; each bank holds 2**IDX_W entries
CH_W, 4, bits per colour channel; must be at least 4
NUM_BANKS, 2, number of palette banks, at least 1
FRAMES_PER_STEP, 2, vsync pulses per fade level step, at least 1

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
pix_index  in  IDX_W  palette index of the current pixel
pix_blank  in  1  1 = outside the active video region
vsync_pulse  in  1  single-cycle pulse, once per frame start
wr_en  in  1  palette write strobe
wr_bank  in  clog2(NUM_BANKS) (minimum 1)  bank to write
wr_addr  in  IDX_W  entry to write
wr_data  in  3*CH_W  {red, green, blue}
swap_req  in  1  pulse: request a bank change
swap_bank  in  clog2(NUM_BANKS) (minimum 1)  requested bank
fade_go  in  1  pulse: start a fade
fade_dir  in  1  1 = fade out (toward black), 0 = fade in
red, green, blue  out  CH_W each  registered pixel colour
active_bank  out  clog2(NUM_BANKS) (minimum 1)  bank currently displayed
swap_pending  out  1  a swap is waiting for vsync
fade_busy  out  1  a fade is in progress
fade_level  out  CH_W  current attenuation; 0 = none, 2**CH_W-1 = black

Behaviour:
Reset (async assert, sync release):
- red/green/blue = 0; active_bank = 0; swap_pending = 0; fade_busy = 0; fade_level = 0; frame counter = 0.
- Every bank is loaded as follows; each channel is a 4-bit value shifted left by CH_W-4:
  - entry 0 = {0,0,0}; 1 = {3,C,D}; 2 = {E,8,1}; 3 = {F,F,F}; 4 = {4,E,2}
  - every other entry = {3,C,D}
- Reset mid-fade or mid-swap returns to these values immediately.

Pixel pipeline, latency 2, fully pipelined, one pixel per clock:
- Stage 1: register entry[active_bank][pix_index] and pix_blank.
- Stage 2: each channel becomes max(channel - fade_level, 0), saturating. Force 0 if blank.

Writes:
- Take effect at the clock edge when wr_en = 1.
- A write to any bank is permitted, including the active bank (no tearing protection).
- A read of the same entry in the same cycle returns the old value.
- A wr_bank >= NUM_BANKS is ignored.

Bank swap:
- swap_req latches swap_bank into pending and sets swap_pending.
- A later swap_req before vsync overwrites pending (last wins).
- On vsync_pulse with swap_pending = 1: active_bank takes pending, swap_pending clears.
- swap_req and vsync_pulse in the same cycle: the new request is applied at that vsync.
- A swap_bank >= NUM_BANKS is ignored (no pending).
- The change is visible at the pixel output 2 cycles after the vsync edge.

Fade engine, with states IDLE and FADING:
- fade_go in IDLE:
  - If fade_level already equals the target (max for out, 0 for in), stay IDLE.
  - Otherwise go to FADING, clear the frame counter, latch fade_dir.
- fade_go in FADING: restart from the current level with the new direction and clear the frame counter.
- Stepping in FADING:
  - Each vsync_pulse increments the frame counter.
  - When the counter reaches FRAMES_PER_STEP, clear it and step fade_level by ±1 toward the target.
  - On reaching the target, return to IDLE on that edge.
- fade_busy = (state == FADING).
- fade_level holds its value in IDLE; a completed fade-out keeps the screen black.
- fade_go and vsync_pulse in the same cycle: fade_go wins and the counter clears (no step).

Test Plan:
- Reset, then pix_index = 2, blank = 0 -> two cycles later RGB = {E,8,1}; index 7 -> {3,C,D}.
- Write bank 1 entry 3 = {1,2,3}, swap_req to bank 1 mid-frame -> output for index 3 remains {F,F,F} and swap_pending = 1. After vsync_pulse: active_bank = 1, swap_pending = 0, index 3 -> {1,2,3} 2 cycles later.
- Write to entry 5 of the active bank while reading index 5 in the same cycle -> that pixel shows the old value; the next read shows the new value.
- FRAMES_PER_STEP = 2, fade_go with dir = 1 -> fade_level steps 0→1 after 2 vsyncs and reaches 15 after 30 vsyncs, then fade_busy = 0. Index 2 shows {D,7,0} at level 1 and {0,0,0} at level 15.
- At level 15 issue fade_go with dir = 0 -> level decreases to 0 and colours are restored. fade_go with dir = 1 mid-fade reverses direction from the current level.
- pix_blank = 1 -> RGB = 0 regardless of index. Assert reset_n low mid-fade with a pending swap -> all outputs 0, palettes restored, active_bank = 0.
